// File: rtl/display_fx_controller_if.sv
// Command port between game logic and the LED-matrix effects controller.
// The master side issues cursor/flash commands; the slave side accepts them.
interface display_fx_controller_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [5:0] cmd_pos;
    logic       cmd_color;
    logic [3:0] cmd_count;
    logic       flash_abort;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_pos,
        output cmd_color,
        output cmd_count,
        output flash_abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_pos,
        input  cmd_color,
        input  cmd_count,
        input  flash_abort,
        output cmd_ready
    );
endinterface

// File: rtl/display_fx_controller.sv
// Flicker clock generator and screen-flash / cursor-flicker sequencer for the
// 8x8 bicolour LED matrix scanner; all outputs are registered in scan_clk.
module display_fx_controller #(
    parameter int FLICKER_DIV = 64,
    parameter int DIV_W       = 8
) (
    input  logic                      scan_clk,
    input  logic                      rst_n_,
    display_fx_controller_if.slave    cmd,
    output logic                      flicker_clk,
    output logic                      screen_flicker_en,
    output logic                      point_flicker_en,
    output logic [5:0]                point_flicker_pos,
    output logic                      point_flicker_color,
    output logic                      busy,
    output logic                      flash_done
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_FLASH_SYNC = 2'b01,
        ST_FLASH      = 2'b10
    } state_e;

    localparam logic [1:0]       OP_NOP        = 2'b00;
    localparam logic [1:0]       OP_CURSOR_SET = 2'b01;
    localparam logic [1:0]       OP_CURSOR_OFF = 2'b10;
    localparam logic [1:0]       OP_FLASH      = 2'b11;
    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(FLICKER_DIV - 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             flicker_clk_q, flicker_clk_d;
    logic [3:0]       remaining_q, remaining_d;
    logic             cursor_en_q, cursor_en_d;
    logic [5:0]       pos_q, pos_d;
    logic             color_q, color_d;
    logic             screen_q, screen_d;
    logic             point_q, point_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cmd_ready;
    logic             accept;
    logic             div_wrap;
    logic             rise_evt;

    assign cmd_ready     = (state_q == ST_IDLE);
    assign cmd.cmd_ready = cmd_ready;

    always_comb begin
        div_wrap      = (div_cnt_q == DIV_LAST);
        div_cnt_d     = div_wrap ? '0 : div_cnt_q + 1'b1;
        flicker_clk_d = flicker_clk_q ^ div_wrap;
        rise_evt      = div_wrap && !flicker_clk_q;
        accept        = cmd.cmd_valid && cmd_ready;

        state_d     = state_q;
        remaining_d = remaining_q;
        cursor_en_d = cursor_en_q;
        pos_d       = pos_q;
        color_d     = color_q;
        screen_d    = screen_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        OP_NOP: ;
                        OP_CURSOR_SET: begin
                            cursor_en_d = 1'b1;
                            pos_d       = cmd.cmd_pos;
                            color_d     = cmd.cmd_color;
                        end
                        OP_CURSOR_OFF: cursor_en_d = 1'b0;
                        OP_FLASH: begin
                            if (cmd.cmd_count == 4'd0) begin
                                done_d = 1'b1;
                            end else begin
                                remaining_d = cmd.cmd_count;
                                state_d     = ST_FLASH_SYNC;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_FLASH_SYNC: begin
                if (cmd.flash_abort) begin
                    screen_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (rise_evt) begin
                    screen_d = 1'b1;
                    state_d  = ST_FLASH;
                end
            end
            ST_FLASH: begin
                // Each flash closes on a flicker_clk rise, so the enable spans whole red+green periods.
                if (cmd.flash_abort) begin
                    screen_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (rise_evt) begin
                    if (remaining_q > 4'd1) begin
                        remaining_d = remaining_q - 1'b1;
                    end else begin
                        remaining_d = 4'd0;
                        screen_d    = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                screen_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        // Cursor stays dark from the edge the flash starts until one cycle after it ends.
        point_d = cursor_en_d && !screen_d && !screen_q;
        busy_d  = (state_d == ST_FLASH_SYNC) || (state_d == ST_FLASH);
    end

    always_ff @(posedge scan_clk or negedge rst_n_) begin
        if (!rst_n_) begin
            state_q       <= ST_IDLE;
            div_cnt_q     <= '0;
            flicker_clk_q <= 1'b0;
            remaining_q   <= 4'd0;
            cursor_en_q   <= 1'b0;
            pos_q         <= 6'd0;
            color_q       <= 1'b0;
            screen_q      <= 1'b0;
            point_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            flicker_clk_q <= flicker_clk_d;
            remaining_q   <= remaining_d;
            cursor_en_q   <= cursor_en_d;
            pos_q         <= pos_d;
            color_q       <= color_d;
            screen_q      <= screen_d;
            point_q       <= point_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign flicker_clk         = flicker_clk_q;
    assign screen_flicker_en   = screen_q;
    assign point_flicker_en    = point_q;
    assign point_flicker_pos   = pos_q;
    assign point_flicker_color = color_q;
    assign busy                = busy_q;
    assign flash_done          = done_q;

endmodule

// File: tb/tb_display_fx_controller.sv
// Directed bench for display_fx_controller with a schedule-based reference model
// (flash windows computed from acceptance edge and period arithmetic).
module tb_display_fx_controller;
    localparam int FD = 4;
    localparam int P  = 2 * FD;

    logic       scan_clk = 1'b0;
    logic       rst_n_;
    logic       flicker_clk;
    logic       screen_flicker_en;
    logic       point_flicker_en;
    logic [5:0] point_flicker_pos;
    logic       point_flicker_color;
    logic       busy;
    logic       flash_done;

    int checks = 0;
    int errors = 0;

    display_fx_controller_if cmd_if();

    display_fx_controller #(.FLICKER_DIV(FD), .DIV_W(8)) dut (
        .scan_clk            (scan_clk),
        .rst_n_              (rst_n_),
        .cmd                 (cmd_if),
        .flicker_clk         (flicker_clk),
        .screen_flicker_en   (screen_flicker_en),
        .point_flicker_en    (point_flicker_en),
        .point_flicker_pos   (point_flicker_pos),
        .point_flicker_color (point_flicker_color),
        .busy                (busy),
        .flash_done          (flash_done)
    );

    always #5 scan_clk = ~scan_clk;

    // model state: e = clock edges since reset release
    int       e;
    bit       m_cur_en;
    bit [5:0] m_pos;
    bit       m_col;
    bit       fl_on;
    int       fl_rise;
    int       fl_end;
    bit       m_prev_scr;
    bit       x_scr, x_done, x_busy, x_point;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e = 0; m_cur_en = 0; m_pos = 0; m_col = 0;
        fl_on = 0; fl_rise = 0; fl_end = 0; m_prev_scr = 0;
    endtask

    task automatic step();
        int cnt;
        @(posedge scan_clk);
        e++;
        x_done = 0;
        if (fl_on && cmd_if.flash_abort) begin
            fl_on = 0;
        end else if (!fl_on && cmd_if.cmd_valid) begin
            case (cmd_if.cmd_op)
                2'b01: begin m_cur_en = 1; m_pos = cmd_if.cmd_pos; m_col = cmd_if.cmd_color; end
                2'b10: m_cur_en = 0;
                2'b11: begin
                    cnt = int'(cmd_if.cmd_count);
                    if (cnt == 0) begin
                        x_done = 1;
                    end else begin
                        fl_on   = 1;
                        fl_rise = e - (e % P) + FD;
                        if (fl_rise <= e) fl_rise += P;
                        fl_end  = fl_rise + cnt * P;
                    end
                end
                default: ;
            endcase
        end
        x_scr = fl_on && (e >= fl_rise) && (e < fl_end);
        if (fl_on && e == fl_end) begin x_done = 1; fl_on = 0; end
        x_busy     = fl_on;
        x_point    = m_cur_en && !x_scr && !m_prev_scr;
        m_prev_scr = x_scr;
        #1;
        chk("flicker_clk", int'(flicker_clk), (e / FD) % 2);
        chk("screen_flicker_en", int'(screen_flicker_en), int'(x_scr));
        chk("point_flicker_en", int'(point_flicker_en), int'(x_point));
        chk("point_flicker_pos", int'(point_flicker_pos), int'(m_pos));
        chk("point_flicker_color", int'(point_flicker_color), int'(m_col));
        chk("busy", int'(busy), int'(x_busy));
        chk("flash_done", int'(flash_done), int'(x_done));
        chk("cmd_ready", int'(cmd_if.cmd_ready), int'(!x_busy));
    endtask

    task automatic issue(input bit [1:0] op, input bit [5:0] pos, input bit col, input bit [3:0] cnt);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_pos   = pos;
        cmd_if.cmd_color = col;
        cmd_if.cmd_count = cnt;
        step();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_scr(input bit val, input int budget, output int n);
        n = 0;
        while (screen_flicker_en !== val && n < budget) begin
            step();
            n++;
        end
        chk("wait_screen_bound", int'(screen_flicker_en === val), 1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (flash_done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("wait_done_bound", int'(flash_done === 1'b1), 1);
    endtask

    initial begin
        int n, scr_cyc, done_cnt;
        rst_n_ = 1'b0;
        cmd_if.cmd_valid = 0; cmd_if.cmd_op = 0; cmd_if.cmd_pos = 0;
        cmd_if.cmd_color = 0; cmd_if.cmd_count = 0; cmd_if.flash_abort = 0;
        model_reset();
        repeat (2) @(posedge scan_clk);
        #1;
        chk("rst_flicker", int'(flicker_clk), 0);
        chk("rst_ready", int'(cmd_if.cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_screen", int'(screen_flicker_en), 0);
        chk("rst_point", int'(point_flicker_en), 0);
        rst_n_ = 1'b1;
        model_reset();

        // divider: rise at edge 4, fall at edge 8
        repeat (3) step();
        chk("flicker_before_edge4", int'(flicker_clk), 0);
        step();
        chk("flicker_edge4", int'(flicker_clk), 1);
        repeat (3) step();
        chk("flicker_edge7", int'(flicker_clk), 1);
        step();
        chk("flicker_edge8", int'(flicker_clk), 0);

        // cursor set / off / nop
        issue(2'b01, 6'd27, 1'b1, 4'd0);
        chk("cursor_set_en", int'(point_flicker_en), 1);
        chk("cursor_set_pos", int'(point_flicker_pos), 27);
        chk("cursor_set_col", int'(point_flicker_color), 1);
        repeat (2) step();
        issue(2'b10, 6'd0, 1'b0, 4'd0);
        chk("cursor_off_en", int'(point_flicker_en), 0);
        chk("cursor_off_pos", int'(point_flicker_pos), 27);
        issue(2'b00, 6'd9, 1'b0, 4'd0);
        issue(2'b01, 6'd27, 1'b1, 4'd0);

        // flash of 3 with cursor on; CURSOR_OFF attempts while busy are ignored
        issue(2'b11, 6'd0, 1'b0, 4'd3);
        chk("flash3_ready_low", int'(cmd_if.cmd_ready), 0);
        chk("flash3_busy", int'(busy), 1);
        scr_cyc = 0; done_cnt = 0;
        for (int i = 0; i < 100 && done_cnt == 0; i++) begin
            if (i < 3) begin
                cmd_if.cmd_valid = 1'b1;
                cmd_if.cmd_op    = 2'b10;
            end else begin
                cmd_if.cmd_valid = 1'b0;
            end
            step();
            if (screen_flicker_en) begin
                if (scr_cyc == 0) chk("flash3_rise_on_flicker_rise", int'(flicker_clk), 1);
                scr_cyc++;
            end
            if (flash_done) done_cnt++;
        end
        cmd_if.cmd_valid = 1'b0;
        chk("flash3_screen_cycles", scr_cyc, 24);
        step();
        chk("flash3_point_restored", int'(point_flicker_en), 1);
        repeat (3) begin
            step();
            if (flash_done) done_cnt++;
        end
        chk("flash3_done_pulses", done_cnt, 1);

        // zero-count flash
        issue(2'b11, 6'd0, 1'b0, 4'd0);
        chk("flash0_done", int'(flash_done), 1);
        chk("flash0_ready", int'(cmd_if.cmd_ready), 1);
        chk("flash0_screen", int'(screen_flicker_en), 0);
        step();
        chk("flash0_done_clear", int'(flash_done), 0);

        // accept on a rise_evt cycle: waits a full period
        n = 0;
        while (((e + 1) % P) != FD && n < 2 * P) begin step(); n++; end
        issue(2'b11, 6'd0, 1'b0, 4'd1);
        wait_scr(1'b1, 40, n);
        chk("rise_evt_accept_delay", n, P);
        wait_done(40);

        // flash of 5 aborted on a fall_evt cycle
        issue(2'b11, 6'd0, 1'b0, 4'd5);
        wait_scr(1'b1, 40, n);
        repeat (P) step();
        n = 0;
        while (((e + 1) % P) != 0 && n < P) begin step(); n++; end
        cmd_if.flash_abort = 1'b1;
        step();
        cmd_if.flash_abort = 1'b0;
        chk("abort_screen", int'(screen_flicker_en), 0);
        chk("abort_no_done", int'(flash_done), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(cmd_if.cmd_ready), 1);
        step();
        chk("abort_point_restored", int'(point_flicker_en), 1);

        // abort while idle is ignored
        cmd_if.flash_abort = 1'b1;
        repeat (2) step();
        cmd_if.flash_abort = 1'b0;
        chk("idle_abort_ready", int'(cmd_if.cmd_ready), 1);

        // asynchronous reset in the middle of a flash
        issue(2'b11, 6'd0, 1'b0, 4'd2);
        wait_scr(1'b1, 40, n);
        repeat (3) step();
        #3;
        rst_n_ = 1'b0;
        #1;
        chk("midrst_screen", int'(screen_flicker_en), 0);
        chk("midrst_point", int'(point_flicker_en), 0);
        chk("midrst_pos", int'(point_flicker_pos), 0);
        chk("midrst_color", int'(point_flicker_color), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(flash_done), 0);
        chk("midrst_flicker", int'(flicker_clk), 0);
        chk("midrst_ready", int'(cmd_if.cmd_ready), 1);
        @(posedge scan_clk);
        #1;
        rst_n_ = 1'b1;
        model_reset();
        repeat (4) step();
        chk("postrst_flicker_edge4", int'(flicker_clk), 1);
        issue(2'b01, 6'd5, 1'b0, 4'd0);
        chk("postrst_cursor_en", int'(point_flicker_en), 1);
        chk("postrst_cursor_pos", int'(point_flicker_pos), 5);
        chk("postrst_cursor_col", int'(point_flicker_color), 0);
        repeat (12) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
